// File: rtl/mips_sc_controller_if.sv
// Control bundle between the single-cycle MIPS controller and its datapath/host.
// The slave modport is the controller's view; the master modport is the driver's view.
interface mips_sc_controller_if #(
    parameter int unsigned CNT_W = 16
);
    logic             start;
    logic [31:0]      instruction;
    logic             zeroflag;
    logic             ldinpc;
    logic             initpc;
    logic             JumpSrc;
    logic             PCsignal;
    logic             PCSrc;
    logic             RegDst;
    logic             RegWSrc;
    logic             WriteSrc;
    logic             RegWrite;
    logic             ALUSrc;
    logic             MemtoReg;
    logic             MemRead;
    logic             MemWrite;
    logic [2:0]       ALUoperation;
    logic             busy;
    logic             done;
    logic             illegal;
    logic             timeout;
    logic [CNT_W-1:0] instr_count;

    modport slave (
        input  start, instruction, zeroflag,
        output ldinpc, initpc, JumpSrc, PCsignal, PCSrc,
               RegDst, RegWSrc, WriteSrc, RegWrite,
               ALUSrc, MemtoReg, MemRead, MemWrite, ALUoperation,
               busy, done, illegal, timeout, instr_count
    );

    modport master (
        output start, instruction, zeroflag,
        input  ldinpc, initpc, JumpSrc, PCsignal, PCSrc,
               RegDst, RegWSrc, WriteSrc, RegWrite,
               ALUSrc, MemtoReg, MemRead, MemWrite, ALUoperation,
               busy, done, illegal, timeout, instr_count
    );
endinterface

// File: rtl/mips_sc_controller.sv
// Single-cycle MIPS control decoder plus IDLE/INIT/RUN/HALT run sequencer.
// Optional RUN-cycle watchdog is built when MIPSCTRL_WATCHDOG_EN is defined.
module mips_sc_controller #(
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned MAX_CYCLES = 1000
) (
    input  logic                 clk,
    input  logic                 rst,
    mips_sc_controller_if.slave  bus
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_SUB  = 3'b110;
    localparam logic [2:0] ALU_SLT  = 3'b111;

    typedef struct packed {
        logic       jumpsrc;
        logic       pcsignal;
        logic       pcsrc;
        logic       regdst;
        logic       regwsrc;
        logic       writesrc;
        logic       regwrite;
        logic       alusrc;
        logic       memtoreg;
        logic       memread;
        logic       memwrite;
        logic [2:0] aluop;
    } ctrl_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_INIT = 2'd1,
        S_RUN  = 2'd2,
        S_HALT = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    ctrl_t            w_dec;
    ctrl_t            w_ctrl;
    logic             w_legal;
    logic             w_halt_op;
    logic             w_run;
    logic             w_retire;
    logic             w_enter_init;
    logic             w_wd_hit;
    logic [CNT_W-1:0] r_count;
    logic             r_illegal;
    logic             r_timeout;
    logic [5:0]       w_op;
    logic [5:0]       w_funct;
    logic             w_unused;

    assign w_op     = bus.instruction[31:26];
    assign w_funct  = bus.instruction[5:0];
    assign w_unused = ^bus.instruction[25:6];

    // Raw instruction decode, independent of run state
    always_comb begin
        w_dec     = '0;
        w_legal   = 1'b1;
        w_halt_op = 1'b0;
        unique case (w_op)
            OP_RTYPE: begin
                w_dec.regdst   = 1'b1;
                w_dec.regwrite = 1'b1;
                unique case (w_funct)
                    FN_ADD:  w_dec.aluop = ALU_ADD;
                    FN_SUB:  w_dec.aluop = ALU_SUB;
                    FN_AND:  w_dec.aluop = ALU_AND;
                    FN_OR:   w_dec.aluop = ALU_OR;
                    FN_SLT:  w_dec.aluop = ALU_SLT;
                    FN_JR: begin
                        w_dec          = '0;
                        w_dec.pcsignal = 1'b1;
                    end
                    default: begin
                        w_dec   = '0;
                        w_legal = 1'b0;
                    end
                endcase
            end
            OP_ADDI: begin
                w_dec.alusrc   = 1'b1;
                w_dec.regwrite = 1'b1;
                w_dec.aluop    = ALU_ADD;
            end
            OP_SLTI: begin
                w_dec.alusrc   = 1'b1;
                w_dec.regwrite = 1'b1;
                w_dec.aluop    = ALU_SLT;
            end
            OP_LW: begin
                w_dec.alusrc   = 1'b1;
                w_dec.aluop    = ALU_ADD;
                w_dec.memread  = 1'b1;
                w_dec.memtoreg = 1'b1;
                w_dec.regwrite = 1'b1;
            end
            OP_SW: begin
                w_dec.alusrc   = 1'b1;
                w_dec.aluop    = ALU_ADD;
                w_dec.memwrite = 1'b1;
            end
            OP_BEQ: begin
                w_dec.aluop = ALU_SUB;
                w_dec.pcsrc = bus.zeroflag;
            end
            OP_J: begin
                w_dec.pcsignal = 1'b1;
                w_dec.jumpsrc  = 1'b1;
            end
            OP_JAL: begin
                w_dec.pcsignal = 1'b1;
                w_dec.jumpsrc  = 1'b1;
                w_dec.regwsrc  = 1'b1;
                w_dec.writesrc = 1'b1;
                w_dec.regwrite = 1'b1;
            end
            OP_HALT: w_halt_op = 1'b1;
            default: w_legal   = 1'b0;
        endcase
    end

    assign w_run        = (r_state == S_RUN);
    assign w_retire     = w_run && w_legal && !w_halt_op;
    assign w_ctrl       = w_retire ? w_dec : '0;
    assign w_enter_init = ((r_state == S_IDLE) || (r_state == S_HALT)) && bus.start;

`ifdef MIPSCTRL_WATCHDOG_EN
    localparam int unsigned CYC_W = (MAX_CYCLES < 2) ? 1 : $clog2(MAX_CYCLES);

    logic [CYC_W-1:0] r_cyc;

    // RUN-cycle counter; the limit edge is the one where MAX_CYCLES RUN edges have elapsed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cyc <= '0;
        end else if (w_enter_init) begin
            r_cyc <= '0;
        end else if (w_run) begin
            r_cyc <= r_cyc + CYC_W'(1);
        end
    end

    assign w_wd_hit = w_run && (MAX_CYCLES != 0) && (r_cyc == CYC_W'(MAX_CYCLES - 1));
`else
    localparam int unsigned UNUSED_MAX_CYCLES = MAX_CYCLES;

    assign w_wd_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: if (bus.start) w_state_nxt = S_INIT;
            S_INIT: w_state_nxt = S_RUN;
            S_RUN:  if (w_halt_op || !w_legal || w_wd_hit) w_state_nxt = S_HALT;
            S_HALT: if (bus.start) w_state_nxt = S_INIT;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Retire counter and sticky status; a halt opcode at the limit edge suppresses timeout
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count   <= '0;
            r_illegal <= 1'b0;
            r_timeout <= 1'b0;
        end else if (w_enter_init) begin
            r_count   <= '0;
            r_illegal <= 1'b0;
            r_timeout <= 1'b0;
        end else if (w_run) begin
            if (w_retire && (r_count != '1)) begin
                r_count <= r_count + CNT_W'(1);
            end
            if (!w_legal) begin
                r_illegal <= 1'b1;
            end
            if (w_wd_hit && w_legal && !w_halt_op) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign bus.ldinpc       = w_retire;
    assign bus.initpc       = (r_state == S_INIT);
    assign bus.JumpSrc      = w_ctrl.jumpsrc;
    assign bus.PCsignal     = w_ctrl.pcsignal;
    assign bus.PCSrc        = w_ctrl.pcsrc;
    assign bus.RegDst       = w_ctrl.regdst;
    assign bus.RegWSrc      = w_ctrl.regwsrc;
    assign bus.WriteSrc     = w_ctrl.writesrc;
    assign bus.RegWrite     = w_ctrl.regwrite;
    assign bus.ALUSrc       = w_ctrl.alusrc;
    assign bus.MemtoReg     = w_ctrl.memtoreg;
    assign bus.MemRead      = w_ctrl.memread;
    assign bus.MemWrite     = w_ctrl.memwrite;
    assign bus.ALUoperation = w_ctrl.aluop;
    assign bus.busy         = (r_state == S_INIT) || (r_state == S_RUN);
    assign bus.done         = (r_state == S_HALT);
    assign bus.illegal      = r_illegal;
    assign bus.timeout      = r_timeout;
    assign bus.instr_count  = r_count;

endmodule

// File: tb/tb_mips_sc_controller.sv
// Directed self-checking bench for mips_sc_controller; strobes are packed as
// {ldinpc,initpc,JumpSrc,PCsignal,PCSrc,RegDst,RegWSrc,WriteSrc,RegWrite,ALUSrc,MemtoReg,MemRead,MemWrite,ALUoperation}.
module tb_mips_sc_controller;

    localparam logic [31:0] I_ADDI = 32'h2001_0005;
    localparam logic [31:0] I_ADD  = 32'h0022_1820;
    localparam logic [31:0] I_SUB  = 32'h0022_1822;
    localparam logic [31:0] I_AND  = 32'h0022_1824;
    localparam logic [31:0] I_OR   = 32'h0022_1825;
    localparam logic [31:0] I_SLT  = 32'h0022_182A;
    localparam logic [31:0] I_SLTI = 32'h2822_0001;
    localparam logic [31:0] I_SW   = 32'hAC03_0000;
    localparam logic [31:0] I_LW   = 32'h8C04_0000;
    localparam logic [31:0] I_BEQ  = 32'h1022_0002;
    localparam logic [31:0] I_J    = 32'h0800_0000;
    localparam logic [31:0] I_JAL  = 32'h0C00_0003;
    localparam logic [31:0] I_JR   = 32'h03E0_0008;
    localparam logic [31:0] I_HALT = 32'hFC00_0000;
    localparam logic [31:0] I_BADOP = 32'hF800_0000;
    localparam logic [31:0] I_BADFN = 32'h0000_0001;

    logic        clk;
    logic        rst;
    logic [15:0] strobes;
    int          checks;
    int          errors;

    mips_sc_controller_if #(.CNT_W(16)) bus ();

    mips_sc_controller #(.CNT_W(16), .MAX_CYCLES(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    assign strobes = {bus.ldinpc, bus.initpc, bus.JumpSrc, bus.PCsignal, bus.PCSrc,
                      bus.RegDst, bus.RegWSrc, bus.WriteSrc, bus.RegWrite, bus.ALUSrc,
                      bus.MemtoReg, bus.MemRead, bus.MemWrite, bus.ALUoperation};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse start, then advance into RUN; returns just after the INIT->RUN edge
    task automatic start_run();
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        checks++;
        if (strobes !== 16'h4000 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL init_state strobes=%h busy=%b expected strobes=4000 busy=1", strobes, bus.busy);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (strobes !== 16'h0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.illegal !== 1'b0 ||
            bus.timeout !== 1'b0 || bus.instr_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_state strobes=%h busy=%b done=%b ill=%b to=%b cnt=%0d expected all zero",
                     strobes, bus.busy, bus.done, bus.illegal, bus.timeout, bus.instr_count);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (bus.busy !== 1'b0 || strobes !== 16'h0) begin
            errors++;
            $display("FAIL idle_no_start busy=%b strobes=%h expected busy=0 strobes=0000", bus.busy, strobes);
        end
    endtask

    task automatic test_program();
        logic [31:0] prog [5];
        logic [15:0] exp  [5];
        prog = '{I_ADDI, I_ADD, I_SW, I_LW, I_HALT};
        exp  = '{16'h80C2, 16'h8482, 16'h804A, 16'h80F2, 16'h0000};
        start_run();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.instruction = prog[i];
            #1;
            checks++;
            if (strobes !== exp[i]) begin
                errors++;
                $display("FAIL program_step%0d strobes=%h expected %h", i, strobes, exp[i]);
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.instr_count !== 16'd4 || bus.illegal !== 1'b0) begin
            errors++;
            $display("FAIL program_end done=%b busy=%b cnt=%0d ill=%b expected done=1 busy=0 cnt=4 ill=0",
                     bus.done, bus.busy, bus.instr_count, bus.illegal);
        end
    endtask

    task automatic test_alu_ops();
        logic [31:0] prog [5];
        logic [15:0] exp  [5];
        prog = '{I_SUB, I_AND, I_OR, I_SLT, I_SLTI};
        exp  = '{16'h8486, 16'h8480, 16'h8481, 16'h8487, 16'h80C7};
        start_run();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.instruction = prog[i];
            #1;
            checks++;
            if (strobes !== exp[i]) begin
                errors++;
                $display("FAIL alu_op%0d strobes=%h expected %h", i, strobes, exp[i]);
            end
        end
        @(negedge clk);
        bus.instruction = I_HALT;
        @(posedge clk);
        #1;
        checks++;
        if (bus.done !== 1'b1 || bus.instr_count !== 16'd5) begin
            errors++;
            $display("FAIL alu_end done=%b cnt=%0d expected done=1 cnt=5", bus.done, bus.instr_count);
        end
    endtask

    task automatic test_beq();
        start_run();
        @(negedge clk);
        bus.instruction = I_BEQ;
        bus.zeroflag    = 1'b1;
        #1;
        checks++;
        if (strobes !== 16'h8806) begin
            errors++;
            $display("FAIL beq_taken strobes=%h expected 8806", strobes);
        end
        @(negedge clk);
        bus.zeroflag = 1'b0;
        #1;
        checks++;
        if (strobes !== 16'h8006) begin
            errors++;
            $display("FAIL beq_not_taken strobes=%h expected 8006", strobes);
        end
        @(negedge clk);
        bus.instruction = I_HALT;
        @(posedge clk);
        #1;
        checks++;
        if (bus.done !== 1'b1 || bus.instr_count !== 16'd2) begin
            errors++;
            $display("FAIL beq_end done=%b cnt=%0d expected done=1 cnt=2", bus.done, bus.instr_count);
        end
    endtask

    // start is held high throughout RUN and into HALT
    task automatic test_jal_jr();
        logic [31:0] prog [3];
        logic [15:0] exp  [3];
        prog = '{I_JAL, I_JR, I_J};
        exp  = '{16'hB380, 16'h9000, 16'hB000};
        start_run();
        bus.start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.instruction = prog[i];
            #1;
            checks++;
            if (strobes !== exp[i] || bus.busy !== 1'b1) begin
                errors++;
                $display("FAIL jump_step%0d strobes=%h busy=%b expected %h busy=1", i, strobes, bus.busy, exp[i]);
            end
        end
        @(negedge clk);
        bus.instruction = I_HALT;
        @(posedge clk);
        #1;
        checks++;
        if (bus.done !== 1'b1 || bus.instr_count !== 16'd3) begin
            errors++;
            $display("FAIL jump_end done=%b cnt=%0d expected done=1 cnt=3", bus.done, bus.instr_count);
        end
        @(posedge clk);
        #1;
        checks++;
        if (strobes !== 16'h4000 || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL held_start_reinit strobes=%h busy=%b done=%b expected 4000 busy=1 done=0",
                     strobes, bus.busy, bus.done);
        end
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        bus.instruction = I_HALT;
        @(posedge clk);
        #1;
        checks++;
        if (bus.done !== 1'b1 || bus.instr_count !== 16'd0) begin
            errors++;
            $display("FAIL reinit_halt done=%b cnt=%0d expected done=1 cnt=0", bus.done, bus.instr_count);
        end
    endtask

    task automatic test_illegal();
        start_run();
        @(negedge clk);
        bus.instruction = I_ADDI;
        @(negedge clk);
        bus.instruction = I_BADOP;
        #1;
        checks++;
        if (strobes !== 16'h0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL bad_op_strobes strobes=%h busy=%b expected 0000 busy=1", strobes, bus.busy);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.done !== 1'b1 || bus.illegal !== 1'b1 || bus.instr_count !== 16'd1) begin
            errors++;
            $display("FAIL bad_op_halt done=%b ill=%b cnt=%0d expected done=1 ill=1 cnt=1",
                     bus.done, bus.illegal, bus.instr_count);
        end
        bus.instruction = I_ADDI;
        start_run();
        checks++;
        if (bus.illegal !== 1'b0 || bus.instr_count !== 16'd0) begin
            errors++;
            $display("FAIL restart_clears ill=%b cnt=%0d expected ill=0 cnt=0", bus.illegal, bus.instr_count);
        end
        @(negedge clk);
        bus.instruction = I_BADFN;
        #1;
        checks++;
        if (strobes !== 16'h0) begin
            errors++;
            $display("FAIL bad_funct_strobes strobes=%h expected 0000", strobes);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.done !== 1'b1 || bus.illegal !== 1'b1 || bus.instr_count !== 16'd0) begin
            errors++;
            $display("FAIL bad_funct_halt done=%b ill=%b cnt=%0d expected done=1 ill=1 cnt=0",
                     bus.done, bus.illegal, bus.instr_count);
        end
    endtask

    task automatic test_watchdog();
        bit seen_done;
        bus.instruction = I_J;
        start_run();
`ifdef MIPSCTRL_WATCHDOG_EN
        seen_done = 1'b0;
        for (int i = 0; i < 20 && !seen_done; i++) begin
            @(posedge clk);
            #1;
            seen_done = bus.done;
        end
        checks++;
        if (!seen_done || bus.timeout !== 1'b1 || bus.instr_count !== 16'd5 || bus.illegal !== 1'b0) begin
            errors++;
            $display("FAIL watchdog_timeout done=%b to=%b cnt=%0d ill=%b expected done=1 to=1 cnt=5 ill=0",
                     bus.done, bus.timeout, bus.instr_count, bus.illegal);
        end
        // Halt opcode on the limit edge takes priority over the watchdog
        start_run();
        repeat (4) @(posedge clk);
        @(negedge clk);
        bus.instruction = I_HALT;
        @(posedge clk);
        #1;
        checks++;
        if (bus.done !== 1'b1 || bus.timeout !== 1'b0 || bus.instr_count !== 16'd4) begin
            errors++;
            $display("FAIL halt_beats_watchdog done=%b to=%b cnt=%0d expected done=1 to=0 cnt=4",
                     bus.done, bus.timeout, bus.instr_count);
        end
`else
        seen_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            seen_done = seen_done | bus.done;
        end
        checks++;
        if (seen_done || bus.busy !== 1'b1 || bus.timeout !== 1'b0 || bus.instr_count !== 16'd12) begin
            errors++;
            $display("FAIL no_watchdog_loop done_seen=%b busy=%b to=%b cnt=%0d expected 0 1 0 12",
                     seen_done, bus.busy, bus.timeout, bus.instr_count);
        end
        @(negedge clk);
        bus.instruction = I_HALT;
        @(posedge clk);
        #1;
        checks++;
        if (bus.done !== 1'b1 || bus.timeout !== 1'b0) begin
            errors++;
            $display("FAIL no_watchdog_halt done=%b to=%b expected done=1 to=0", bus.done, bus.timeout);
        end
`endif
    endtask

    task automatic test_reset_mid_run();
        bus.instruction = I_LW;
        start_run();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (strobes !== 16'h80F2 || bus.instr_count !== 16'd2) begin
            errors++;
            $display("FAIL pre_reset_lw strobes=%h cnt=%0d expected 80F2 cnt=2", strobes, bus.instr_count);
        end
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (strobes !== 16'h0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.instr_count !== 16'd0) begin
            errors++;
            $display("FAIL mid_run_reset strobes=%h busy=%b done=%b cnt=%0d expected 0000 0 0 0",
                     strobes, bus.busy, bus.done, bus.instr_count);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (bus.busy !== 1'b0 || strobes !== 16'h0) begin
            errors++;
            $display("FAIL post_reset_idle busy=%b strobes=%h expected busy=0 strobes=0000", bus.busy, strobes);
        end
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        rst             = 1'b1;
        bus.start       = 1'b0;
        bus.instruction = I_LW;
        bus.zeroflag    = 1'b0;
        test_reset();
        test_program();
        test_alu_ops();
        test_beq();
        test_jal_jr();
        test_illegal();
        test_watchdog();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_sc_controller.md
# mips_sc_controller

Control unit and run sequencer for the single-cycle MIPS datapath. Decodes the current instruction word and the ALU zero flag into the datapath's control strobes, and owns a small run FSM. The FSM clears the PC on start, enables one instruction retirement per clock, and stops on a halt or illegal opcode. It sits directly upstream of the datapath, driving every one of its control inputs.

## Interface
- `CNT_W`, default 16: width of the retired-instruction counter.
- `MAX_CYCLES`, default 1000: watchdog limit in RUN cycles; used only with `MIPSCTRL_WATCHDOG_EN`.
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, asynchronous, active-high.
- `start`, in, 1: level/pulse; sampled in IDLE and HALT.
- `instruction`, in, 32: current instruction from instruction memory.
- `zeroflag`, in, 1: ALU zero flag.
- `ldinpc`, `initpc`, out, 1 each: PC load and PC clear.
- `JumpSrc`, `PCsignal`, `PCSrc`, out, 1 each: next-PC selects (1 = jump target / jump path / branch target).
- `RegDst`, `RegWSrc`, `WriteSrc`, `RegWrite`, out, 1 each: rd select, $31 select, PC+4 write-back select, register write enable.
- `ALUSrc`, `MemtoReg`, `MemRead`, `MemWrite`, out, 1 each.
- `ALUoperation`, out, 3: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT.
- `busy`, out, 1: high in INIT and RUN.
- `done`, out, 1: high in HALT.
- `illegal`, out, 1: sticky; the halt was caused by an undecodable instruction.
- `timeout`, out, 1: sticky watchdog flag.
- `instr_count`, out, `CNT_W`: instructions retired since the last start.

## Operation
- States: IDLE, INIT, RUN, HALT.
  - IDLE→INIT on `start`.
  - INIT→RUN unconditionally.
  - RUN→HALT on a halt opcode (op 0x3F), an illegal encoding, or the watchdog.
  - HALT→INIT on `start`.
- Control strobes are combinational from `instruction`/`zeroflag`, gated by state. Outside RUN, all strobes are 0, except `initpc` = 1 in INIT.
- In RUN, `ldinpc` = 1 for every legal non-halt instruction. Any strobe not listed below is 0.
  - R-type (op 0x00): `RegDst` = 1, `RegWrite` = 1, ALU op from funct: 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x2A SLT.
  - jr (op 0x00, funct 0x08): `PCsignal` = 1, `JumpSrc` = 0, `RegWrite` = 0.
  - addi (0x08): `ALUSrc` = 1, `RegWrite` = 1, ADD.
  - slti (0x0A): `ALUSrc` = 1, `RegWrite` = 1, SLT.
  - lw (0x23): `ALUSrc` = 1, ADD, `MemRead` = 1, `MemtoReg` = 1, `RegWrite` = 1.
  - sw (0x2B): `ALUSrc` = 1, ADD, `MemWrite` = 1.
  - beq (0x04): SUB, `PCSrc` = `zeroflag`.
  - j (0x02): `PCsignal` = 1, `JumpSrc` = 1.
  - jal (0x03): `PCsignal` = 1, `JumpSrc` = 1, `RegWSrc` = 1, `WriteSrc` = 1, `RegWrite` = 1.
- Halt opcode and illegal encodings (any other op, or any other funct under op 0x00) drive all strobes to 0, so nothing is written and the PC does not load. `illegal` is set only for illegal encodings.
- `instr_count`:
  - Increments at each RUN clock edge with a legal non-halt instruction.
  - Cleared in INIT.
  - Saturates at all-ones; no wrap.
- `illegal` and `timeout` are cleared in INIT.

## Timing
- Reset (asynchronous): state IDLE; all outputs 0, including `instr_count`, `busy`, `done`, `illegal`, and `timeout`. Reset mid-RUN forces all strobes to 0 immediately.
- Start latency:
  - `start` high at edge N: INIT during cycle N..N+1, with `initpc` = 1, so the PC clears at edge N+1.
  - RUN from N+1; the first instruction retires at edge N+2.
- One instruction per clock in RUN; decode is zero-latency combinational.
- Halt opcode present at edge M: `done` = 1 from M. `instr_count` is not incremented at M.
- `start` is ignored while in INIT or RUN. A `start` held high in HALT re-enters INIT at the next edge.

## Configuration
- `MIPSCTRL_WATCHDOG_EN` defined:
  - A RUN-cycle counter runs. When it reaches `MAX_CYCLES`, the FSM goes RUN→HALT at that edge and sets `timeout`.
  - If a halt opcode and the limit occur at the same edge, the halt wins and `timeout` stays 0.
- Not defined: no cycle counter is built; `timeout` is tied to 0; RUN ends only on halt or illegal.

## Test plan
- Reset mid-RUN with `instruction` = lw: all strobes 0 at once, state IDLE, `instr_count` = 0.
- `start` pulse, then program `addi`, `add`, `sw`, `lw`, `halt` (op 0x3F):
  - `initpc` high for exactly 1 cycle.
  - Strobes match the decode table on each cycle.
  - `done` = 1 and `instr_count` = 4.
- beq with `zeroflag` = 1 gives `PCSrc` = 1; with `zeroflag` = 0 gives `PCSrc` = 0. ALUoperation = 110 in both cases.
- Instructions 0x0C000003 (jal) then jr (funct 0x08):
  - jal: `PCsignal` = `JumpSrc` = `RegWSrc` = `WriteSrc` = `RegWrite` = 1.
  - jr: `PCsignal` = 1, `JumpSrc` = 0.
- Instruction op 0x3E: no strobes, HALT next edge, `illegal` = 1. A second `start` clears `illegal` and `instr_count`.
- With `MIPSCTRL_WATCHDOG_EN` and `MAX_CYCLES` = 5, an infinite `j` loop halts with `timeout` = 1 and `instr_count` = 5.
